// File: rtl/instruction_loader.sv
// instruction_loader: framed byte-stream loader (length, payload, checksum) driving the instruction memory write port.
// Define INSTR_LOADER_CHECKSUM_EN to require the trailing checksum byte and enable load_error.
module instruction_loader #(
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] start_addr,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       busy,
    output logic       load_done,
    output logic       load_error
);

    // A length byte of zero encodes a full-memory frame.
    localparam logic [8:0] FULL_FRAME = 9'(MEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
`ifdef INSTR_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [8:0] remaining_q, remaining_d;
    logic       mem_we_q, mem_we_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic [7:0] mem_wdata_q, mem_wdata_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
    logic       load_error_q, load_error_d;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
        sum_d        = sum_q;
        load_error_d = load_error_q;
`endif
        in_ready  = 1'b0;
        busy      = 1'b1;
        load_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    addr_d  = start_addr;
                    state_d = S_LEN;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    sum_d        = '0;
                    load_error_d = 1'b0;
`endif
                end
            end
            S_LEN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    remaining_d = (in_data == '0) ? FULL_FRAME : {1'b0, in_data};
                    state_d     = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = in_data;
                    addr_d      = addr_q + 8'd1;
                    remaining_d = remaining_q - 9'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    sum_d = sum_q + in_data;
                    if (remaining_q == 9'd1) state_d = S_CHK;
`else
                    if (remaining_q == 9'd1) state_d = S_DONE;
`endif
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CHK: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (8'(sum_q + in_data) != '0) load_error_d = 1'b1;
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                load_done = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum_q        <= '0;
            load_error_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
            load_error_q <= load_error_d;
`endif
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    assign load_error = load_error_q;
`else
    assign load_error = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: table of short frames plus hand-written stall, full-frame and reset sequences.
// Follows INSTR_LOADER_CHECKSUM_EN the same way the design does.
module tb_instruction_loader;

    logic       clk = 1'b0;
    logic       rst_n, start, in_valid;
    logic [7:0] start_addr, in_data;
    logic       in_ready, mem_we, busy, load_done, load_error;
    logic [7:0] mem_addr, mem_wdata;

    always #5 clk = ~clk;

`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    instruction_loader #(.MEM_DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .load_done(load_done), .load_error(load_error)
    );

    typedef struct {
        string           name;
        logic [7:0]      saddr;
        int unsigned     n;
        logic [0:3][7:0] data;
        logic [7:0]      chk;
        logic [0:3][7:0] exp_addr;
        logic            exp_err;
    } vec_t;

    int unsigned tests = 0, fails = 0;
    int unsigned cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
    logic [7:0]  wr_addr[$], wr_data[$];
    int unsigned wr_cyc[$];
    logic [7:0]  payload[256], exp_a[256], exp_d[256];
    logic [7:0]  chk_byte;
    logic        err_at_len;

    // Write-port / done monitor, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            wr_cyc.push_back(cyc);
        end
        if (load_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [7:0] a);
        start = 1'b1;
        start_addr = a;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
        err_at_len = load_error;
    endtask

    // Present one byte and hold it until it has been accepted; returns on the following negedge.
    task automatic send_byte(input logic [7:0] b, input bit stall, input bit poke);
        int unsigned guard = 0;
        if (poke || (stall && $urandom_range(0, 1) == 1)) begin
            in_valid = 1'b0;
            in_data  = 8'hEE;
            if (poke) begin
                start = 1'b1;
                start_addr = 8'h99;
            end
            repeat ($urandom_range(1, 2)) @(negedge clk);
            start = 1'b0;
        end
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("handshake_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] saddr, input int unsigned n, input bit stall, input bit poke);
        int unsigned g = 0;
        clear_log();
        do_start(saddr);
        send_byte(8'(n), stall, 1'b0);
        for (int i = 0; i < int'(n); i++) send_byte(payload[i], stall, poke && i == 2);
        if (CHK_EN) send_byte(chk_byte, stall, 1'b0);
        in_valid = 1'b0;
        while (busy && g < 20) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic verify(input string name, input int unsigned n, input bit timed, input logic exp_err);
        int unsigned bad = 0;
        check({name, "_nwrites"}, wr_addr.size(), n);
        for (int i = 0; i < int'(n) && i < wr_addr.size(); i++) begin
            if (wr_addr[i] !== exp_a[i] || wr_data[i] !== exp_d[i]) bad++;
            if (timed && wr_cyc[i] != start_cyc + 2 + i) bad++;
        end
        check({name, "_writes"}, bad, 0);
        check({name, "_done_pulses"}, done_cnt, 1);
        // load_done is seen N+2 edges after the start edge (N+1 without the checksum byte).
        if (timed) check({name, "_latency"}, done_cyc - start_cyc, n + (CHK_EN ? 2 : 1));
        check({name, "_error"}, {31'd0, load_error}, {31'd0, CHK_EN ? exp_err : 1'b0});
        check({name, "_err_clr_on_start"}, {31'd0, err_at_len}, 32'd0);
        check({name, "_idle_ready"}, {31'd0, in_ready}, 32'd0);
        check({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_we"}, {31'd0, mem_we}, 32'd0);
        check({name, "_addr"}, {24'd0, mem_addr}, 32'd0);
        check({name, "_wdata"}, {24'd0, mem_wdata}, 32'd0);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_done"}, {31'd0, load_done}, 32'd0);
        check({name, "_error"}, {31'd0, load_error}, 32'd0);
        check({name, "_ready"}, {31'd0, in_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        // 0x31 is the sum of AA,BB,CC: 0xCB leaves 0xFC (error), 0xCF closes to zero.
        vecs[0] = '{"load4",   8'h10, 4, {8'h11, 8'h22, 8'h33, 8'h44}, 8'h56, {8'h10, 8'h11, 8'h12, 8'h13}, 1'b0};
        vecs[1] = '{"badchk",  8'h10, 4, {8'h11, 8'h22, 8'h33, 8'h44}, 8'h57, {8'h10, 8'h11, 8'h12, 8'h13}, 1'b1};
        vecs[2] = '{"wrap",    8'hFE, 3, {8'hAA, 8'hBB, 8'hCC, 8'h00}, 8'hCB, {8'hFE, 8'hFF, 8'h00, 8'h00}, 1'b1};
        vecs[3] = '{"wrap_ok", 8'hFE, 3, {8'hAA, 8'hBB, 8'hCC, 8'h00}, 8'hCF, {8'hFE, 8'hFF, 8'h00, 8'h00}, 1'b0};
        vecs[4] = '{"single",  8'h80, 1, {8'h7F, 8'h00, 8'h00, 8'h00}, 8'h81, {8'h80, 8'h00, 8'h00, 8'h00}, 1'b0};

        rst_n = 1'b0; start = 1'b0; start_addr = '0; in_data = '0; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < int'(vecs[v].n); i++) begin
                payload[i] = vecs[v].data[i];
                exp_d[i]   = vecs[v].data[i];
                exp_a[i]   = vecs[v].exp_addr[i];
            end
            chk_byte = vecs[v].chk;
            run_frame(vecs[v].saddr, vecs[v].n, 1'b0, 1'b0);
            verify(vecs[v].name, vecs[v].n, 1'b1, vecs[v].exp_err);
            if (vecs[v].exp_err) begin
                repeat (3) @(negedge clk);
                check({vecs[v].name, "_sticky"}, {31'd0, load_error}, {31'd0, CHK_EN});
            end
        end

        // Stalled frame with a start pulse during DATA that must be ignored.
        for (int i = 0; i < 6; i++) begin
            payload[i] = 8'(i + 1);
            exp_d[i]   = 8'(i + 1);
            exp_a[i]   = 8'(8'h20 + i);
        end
        chk_byte = 8'hEB;
        run_frame(8'h20, 6, 1'b1, 1'b1);
        verify("stall", 6, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("stall_no_restart", {31'd0, busy}, 32'd0);

        // Length byte 0: 256 bytes, addr == data, wraps back to start.
        for (int i = 0; i < 256; i++) begin
            payload[i] = 8'(i);
            exp_d[i]   = 8'(i);
            exp_a[i]   = 8'(i);
        end
        chk_byte = 8'h80;
        run_frame(8'h00, 256, 1'b0, 1'b0);
        verify("len0", 256, 1'b1, 1'b0);

        // Reset after 2 of 4 data bytes, then a clean reload.
        clear_log();
        do_start(8'h40);
        send_byte(8'h04, 1'b0, 1'b0);
        send_byte(8'hA1, 1'b0, 1'b0);
        send_byte(8'hA2, 1'b0, 1'b0);
        in_data = 8'hA3;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_nwrites", wr_addr.size(), 2);
        check("midrst_w0", {wr_addr[0], wr_data[0]}, 32'h40A1);
        check("midrst_w1", {wr_addr[1], wr_data[1]}, 32'h41A2);
        check("midrst_no_done", done_cnt, 0);

        for (int i = 0; i < 4; i++) begin
            payload[i] = vecs[0].data[i];
            exp_d[i]   = vecs[0].data[i];
            exp_a[i]   = vecs[0].exp_addr[i];
        end
        chk_byte = vecs[0].chk;
        run_frame(vecs[0].saddr, 4, 1'b0, 1'b0);
        verify("reload", 4, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
